// File: rtl/ein_loopback_rx.sv
// EIN loopback receiver: conditions the EMO/EDI/ECI pad lines, decodes frames into bytes
// and queues bytes plus end-of-frame status words in a first-word-fall-through FIFO.
module ein_loopback_rx #(
  parameter int unsigned FILTER_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES  = 65535,
  parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        emo_in,
  input  logic        edi_in,
  input  logic        eci_in,
  output logic [8:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        frame_active,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int unsigned FLT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RX    = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;
  localparam logic [1:0] S_EOF   = 2'd3;

  // Line index: 0 = EMO, 1 = EDI, 2 = ECI
  logic [2:0]            r_sync1;
  logic [2:0]            r_sync2;
  logic [2:0]            r_filt;
  logic [2:0][FLT_W-1:0] r_flt_cnt;
  logic                  r_emo_d;
  logic                  r_eci_d;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shreg;
  logic [TMR_W-1:0] r_timer;
  logic             r_overflow;
  logic             r_timeout;
  logic             r_partial;
  logic             r_byte_pend;

  logic [8:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [8:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_active;
  logic             r_frame_done;
  logic [15:0]      r_frame_count;

  logic             w_emo_rise;
  logic             w_emo_fall;
  logic             w_eci_edge;
  logic             w_rx_start;
  logic             w_shift;
  logic             w_to;
  logic             w_eof_wr;
  logic             w_full;
  logic             w_byte_ok;
  logic             w_push;
  logic             w_pop;
  logic [8:0]       w_push_data;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_left;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [8:0]       w_head_nxt;

  // Synchronize, then accept a line change only after it has been stable long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_filt    <= '0;
      r_flt_cnt <= '0;
      r_emo_d   <= 1'b0;
      r_eci_d   <= 1'b0;
    end else begin
      r_sync1 <= {eci_in, edi_in, emo_in};
      r_sync2 <= r_sync1;
      r_emo_d <= r_filt[0];
      r_eci_d <= r_filt[2];
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_filt[i]) begin
          if (r_flt_cnt[i] == FLT_W'(FILTER_CYCLES - 1)) begin
            r_filt[i]    <= r_sync2[i];
            r_flt_cnt[i] <= '0;
          end else begin
            r_flt_cnt[i] <= r_flt_cnt[i] + 1'b1;
          end
        end else begin
          r_flt_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_emo_rise = r_filt[0] & ~r_emo_d;
  assign w_emo_fall = ~r_filt[0] & r_emo_d;
  assign w_eci_edge = r_filt[2] ^ r_eci_d;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Frame sequencing; an EMO fall outranks a same-cycle ECI edge
  always_comb begin
    w_state_nxt = r_state;
    w_rx_start  = 1'b0;
    w_shift     = 1'b0;
    w_to        = 1'b0;
    w_eof_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_emo_rise && enable) begin
          w_state_nxt = S_RX;
          w_rx_start  = 1'b1;
        end
      end
      S_RX: begin
        if (w_emo_fall) begin
          w_state_nxt = S_EOF;
        end else if (w_eci_edge) begin
          w_shift = 1'b1;
        end else if (r_timer == TMR_W'(TIMEOUT_CYCLES)) begin
          w_to        = 1'b1;
          w_state_nxt = S_ABORT;
        end
      end
      S_ABORT: begin
        if (!r_filt[0]) w_state_nxt = S_EOF;
      end
      S_EOF: begin
        if (!w_full) begin
          w_eof_wr    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shifter, idle timer and per-frame status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bitcnt    <= '0;
      r_shreg     <= '0;
      r_timer     <= '0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
      r_partial   <= 1'b0;
      r_byte_pend <= 1'b0;
    end else begin
      r_byte_pend <= 1'b0;
      if (w_rx_start) begin
        r_bitcnt   <= '0;
        r_shreg    <= '0;
        r_overflow <= 1'b0;
        r_timeout  <= 1'b0;
        r_partial  <= 1'b0;
      end
      if (w_shift) begin
        r_shreg     <= {r_shreg[6:0], r_filt[1]};
        r_bitcnt    <= r_bitcnt + 3'd1;
        r_byte_pend <= (r_bitcnt == 3'd7);
      end
      if (w_rx_start || w_shift) begin
        r_timer <= '0;
      end else if (r_state == S_RX && r_timer != TMR_W'(TIMEOUT_CYCLES)) begin
        r_timer <= r_timer + 1'b1;
      end
      if (r_state == S_RX && w_emo_fall) r_partial <= (r_bitcnt != 3'd0);
      if (w_to) begin
        r_timeout <= 1'b1;
        r_partial <= (r_bitcnt != 3'd0);
      end
      if (r_byte_pend && !w_byte_ok) r_overflow <= 1'b1;
    end
  end

  // One slot is always held back so the end-of-frame marker can be stored
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_byte_ok   = (r_count < CNT_W'(DEPTH - 1));
  assign w_push      = (r_byte_pend && w_byte_ok) || w_eof_wr;
  assign w_pop       = r_rx_valid && rx_ready;
  assign w_push_data = w_eof_wr ? {1'b1, 5'b0, r_overflow, r_timeout, r_partial} : {1'b0, r_shreg};

  always_comb begin
    w_cnt_nxt    = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_cnt_left   = r_count - CNT_W'(w_pop);
    w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
    w_head_nxt   = '0;
    if (w_cnt_nxt != '0) begin
      if (w_cnt_left == '0) w_head_nxt = w_push_data;
      else                  w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // Registered head of the FIFO plus frame status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_count        <= w_cnt_nxt;
      r_rx_data      <= w_head_nxt;
      r_rx_valid     <= (w_cnt_nxt != '0);
      r_frame_active <= (w_state_nxt == S_RX) || (w_state_nxt == S_ABORT);
      r_frame_done   <= w_eof_wr;
      if (w_eof_wr) r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign frame_active = r_frame_active;
  assign frame_done   = r_frame_done;
  assign frame_count  = r_frame_count;

endmodule

// File: tb/tb_ein_loopback_rx.sv
// Bench for ein_loopback_rx: frames are driven on the pads, the expected FIFO stream is
// queued from the frame contents and a monitor compares every popped entry.
module tb_ein_loopback_rx;

  localparam int unsigned FILT  = 2;
  localparam int unsigned TMO   = 100;
  localparam int unsigned DLOG  = 2;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        emo_in;
  logic        edi_in;
  logic        eci_in;
  logic        rx_ready;
  logic [8:0]  rx_data;
  logic        rx_valid;
  logic        frame_active;
  logic        frame_done;
  logic [15:0] frame_count;

  int         checks = 0;
  int         errors = 0;
  int         ready_mode = 2;
  int         done_pulses = 0;
  int         pops = 0;
  int         model_frames = 0;
  logic [8:0] exp_q [$];

  ein_loopback_rx #(
    .FILTER_CYCLES  (FILT),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH_LOG2(DLOG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .emo_in      (emo_in),
    .edi_in      (edi_in),
    .eci_in      (eci_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_active(frame_active),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor_loop();
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frame_done) done_pulses++;
        if (rx_valid && rx_ready) begin
          pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_entry actual=0x%0h required=none", rx_data);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", int'(rx_data), int'(e));
          end
        end
      end
    end
  endtask

  task automatic ready_loop();
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = ($urandom_range(3) != 0);
        default: rx_ready = 1'b1;
      endcase
    end
  endtask

  // Reference: one byte per 8 bits MSB first, then a marker; a non-draining FIFO keeps DEPTH-1 bytes
  task automatic send_frame(input int nbits, input logic [39:0] data, input bit en,
                            input bit glitch, input bit hold);
    int nbytes;
    int kept;
    int h;
    logic ovf;
    logic part;
    nbytes = nbits / 8;
    kept   = (hold && nbytes > DEPTH - 1) ? DEPTH - 1 : nbytes;
    ovf    = hold && (nbytes > DEPTH - 1);
    part   = ((nbits % 8) != 0);
    if (en) begin
      for (int k = 0; k < kept; k++) exp_q.push_back({1'b0, data[39-8*k -: 8]});
      exp_q.push_back({1'b1, 5'b0, ovf, 1'b0, part});
      model_frames++;
    end
    enable = en;
    cyc(2);
    emo_in = 1'b1;
    cyc(6);
    if (en) enable = 1'($urandom_range(1));
    for (int j = 0; j < nbits; j++) begin
      h = int'($urandom_range(6, 3));
      edi_in = data[39-j];
      if (glitch && j == 3) begin
        cyc(2);
        eci_in = ~eci_in;
        cyc(1);
        eci_in = ~eci_in;
        cyc(3);
      end else begin
        cyc(h);
      end
      eci_in = ~eci_in;
      cyc(h);
    end
    emo_in = 1'b0;
    cyc(12);
    enable = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    cyc(2);
    check("drain_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    int         p0;
    logic [39:0] d;
    reset = 1'b1; enable = 1'b0; emo_in = 1'b0; edi_in = 1'b0; eci_in = 1'b0; rx_ready = 1'b1;
    fork
      monitor_loop();
      ready_loop();
    join_none
    cyc(3);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_frame_active", int'(frame_active), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_frame_count", int'(frame_count), 0);
    reset = 1'b0;
    enable = 1'b1;
    cyc(5);

    // Two clean bytes
    send_frame(16, {8'hA5, 8'h3C, 24'h0}, 1'b1, 1'b0, 1'b0);
    drain();
    check("two_byte_done_pulses", done_pulses, 1);
    check("two_byte_frame_count", int'(frame_count), 1);

    // 11 ones: one byte plus partial bits
    send_frame(11, {11'h7FF, 29'h0}, 1'b1, 1'b0, 1'b0);
    drain();

    // Short glitch on ECI mid-byte
    send_frame(8, {8'hC3, 32'h0}, 1'b1, 1'b1, 1'b0);
    drain();

    // Timeout after three bits, frame held until EMO drops
    exp_q.push_back(9'h103);
    model_frames++;
    emo_in = 1'b1;
    cyc(6);
    for (int j = 0; j < 3; j++) begin
      edi_in = (j != 1);
      cyc(4);
      eci_in = ~eci_in;
      cyc(4);
    end
    cyc(TMO + 30);
    check("timeout_frame_active_held", int'(frame_active), 1);
    check("timeout_no_marker_yet", exp_q.size(), 1);
    emo_in = 1'b0;
    cyc(12);
    drain();
    check("timeout_frame_active_low", int'(frame_active), 0);

    // Random frames with random back-pressure and random enable
    ready_mode = 1;
    for (int f = 0; f < 12; f++) begin
      d = 40'({$urandom(), $urandom()});
      send_frame(int'($urandom_range(40, 1)), d, ($urandom_range(4) != 0), 1'b0, 1'b0);
    end
    ready_mode = 2;
    drain();
    check("random_frame_count", int'(frame_count), model_frames);

    // Five bytes into a stalled FIFO
    ready_mode = 0;
    cyc(3);
    d = 40'h11_22_33_44_55;
    send_frame(40, d, 1'b1, 1'b0, 1'b1);
    check("ovf_head_valid", int'(rx_valid), 1);
    check("ovf_head_data", int'(rx_data), 32'h011);
    p0 = pops;
    ready_mode = 2;
    cyc(20);
    check("ovf_drained_entries", pops - p0, 4);
    check("ovf_empty_after", int'(rx_valid), 0);
    check("ovf_queue_left", exp_q.size(), 0);

    // Reset in the middle of a frame
    ready_mode = 0;
    cyc(3);
    emo_in = 1'b1;
    cyc(6);
    for (int j = 0; j < 12; j++) begin
      edi_in = 1'($urandom_range(1));
      cyc(4);
      eci_in = ~eci_in;
      cyc(4);
    end
    check("midframe_active", int'(frame_active), 1);
    check("midframe_byte_queued", int'(rx_valid), 1);
    reset = 1'b1;
    emo_in = 1'b0; edi_in = 1'b0; eci_in = 1'b0;
    exp_q.delete();
    model_frames = 0;
    done_pulses = 0;
    cyc(1);
    check("midreset_rx_valid", int'(rx_valid), 0);
    check("midreset_frame_active", int'(frame_active), 0);
    reset = 1'b0;
    cyc(10);
    check("midreset_frame_count", int'(frame_count), 0);
    ready_mode = 2;
    send_frame(8, {8'h5A, 32'h0}, 1'b1, 1'b0, 1'b0);
    drain();
    check("post_reset_frame_count", int'(frame_count), 1);
    check("post_reset_done_pulses", done_pulses, 1);

    check("final_frame_count", int'(frame_count), model_frames);
    check("final_queue_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
